// File: rtl/config_frame_loader.sv
// Bitstream frame loader: assembles ROWS-word frames from a valid/ready word stream and strobes one latch column per frame.
// Optional trailing XOR checksum after END is enabled with `define CONFIG_FRAME_CHECKSUM_EN.
module config_frame_loader #(
   parameter int          ROWS          = 4,
   parameter int          NUM_FRAMES    = 20,
   parameter int          FRAME_ADDR_W  = 5,
   parameter int          STROBE_CYCLES = 2,
   parameter logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [31:0]             s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [32*ROWS-1:0]      frame_data,
   output logic [NUM_FRAMES-1:0]   frame_strobe,
   output logic                    busy,
   output logic                    done,
   output logic                    error
);

   localparam int WCNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SCNT_W = 4;
   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_END   = 8'h02;
   localparam logic [FRAME_ADDR_W:0] NUM_FRAMES_W = NUM_FRAMES[FRAME_ADDR_W:0];

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_STROBE,
      ST_HOLD
`ifdef CONFIG_FRAME_CHECKSUM_EN
      , ST_CHK
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic [FRAME_ADDR_W-1:0] index_q, index_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic [SCNT_W-1:0]       scnt_q, scnt_d;
   logic [32*ROWS-1:0]      frame_data_q, frame_data_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic                    ready_c;
   logic                    xfer;
   logic                    idx_ok;
`ifdef CONFIG_FRAME_CHECKSUM_EN
   logic [31:0]             acc_q, acc_d;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         index_q      <= '0;
         wcnt_q       <= '0;
         scnt_q       <= '0;
         frame_data_q <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
         acc_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         wcnt_q       <= wcnt_d;
         scnt_q       <= scnt_d;
         frame_data_q <= frame_data_d;
         done_q       <= done_d;
         error_q      <= error_d;
`ifdef CONFIG_FRAME_CHECKSUM_EN
         acc_q        <= acc_d;
`endif
      end
   end

   always_comb begin
      ready_c = (state_q == ST_IDLE) || (state_q == ST_CMD) || (state_q == ST_DATA);
`ifdef CONFIG_FRAME_CHECKSUM_EN
      ready_c = ready_c || (state_q == ST_CHK);
`endif
   end

   assign xfer   = s_valid && ready_c;
   assign idx_ok = ({1'b0, s_data[FRAME_ADDR_W-1:0]} < NUM_FRAMES_W);

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      wcnt_d       = wcnt_q;
      scnt_d       = scnt_q;
      frame_data_d = frame_data_q;
      done_d       = 1'b0;
      error_d      = error_q;
`ifdef CONFIG_FRAME_CHECKSUM_EN
      acc_d        = acc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (xfer && (s_data == SYNC_WORD)) begin
               state_d = ST_CMD;
               error_d = 1'b0;
`ifdef CONFIG_FRAME_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         ST_CMD: begin
            if (xfer) begin
               case (s_data[31:24])
                  CMD_WRITE: begin
                     if (idx_ok) begin
                        index_d = s_data[FRAME_ADDR_W-1:0];
                        wcnt_d  = '0;
                        state_d = ST_DATA;
                     end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                     end
                  end
                  CMD_END: begin
`ifdef CONFIG_FRAME_CHECKSUM_EN
                     state_d = ST_CHK;
`else
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
`endif
                  end
                  default: begin
                     error_d = 1'b1;
                     state_d = ST_IDLE;
                  end
               endcase
            end
         end
         ST_DATA: begin
            if (xfer) begin
               frame_data_d[32*wcnt_q +: 32] = s_data;
`ifdef CONFIG_FRAME_CHECKSUM_EN
               acc_d = acc_q ^ s_data;
`endif
               if (wcnt_q == WCNT_W'(ROWS-1)) begin
                  state_d = ST_STROBE;
                  scnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         ST_STROBE: begin
            if (scnt_q == SCNT_W'(STROBE_CYCLES-1)) begin
               scnt_d  = '0;
               state_d = ST_HOLD;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         ST_HOLD: state_d = ST_CMD;
`ifdef CONFIG_FRAME_CHECKSUM_EN
         ST_CHK: begin
            if (xfer) begin
               if (s_data == acc_q) done_d  = 1'b1;
               else                 error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobe decodes straight from the registered state so reset drops it on the same edge.
   for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_strobe
      assign frame_strobe[gi] = (state_q == ST_STROBE) && (index_q == FRAME_ADDR_W'(gi));
   end

   assign s_ready    = ready_c;
   assign frame_data = frame_data_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader; a negedge monitor pops expected frames from a scoreboard on each strobe.
module tb_config_frame_loader;

   localparam int          ROWS          = 4;
   localparam int          NUM_FRAMES    = 20;
   localparam int          FRAME_ADDR_W  = 5;
   localparam int          STROBE_CYCLES = 2;
   localparam logic [31:0] SYNC          = 32'hFAB0_FAB1;
   localparam logic [31:0] END_W         = 32'h0200_0000;

   typedef struct {
      logic [FRAME_ADDR_W-1:0] idx;
      logic [32*ROWS-1:0]      data;
   } frame_t;

   logic                  CLK = 1'b0;
   logic                  RST = 1'b1;
   logic [31:0]           s_data = '0;
   logic                  s_valid = 1'b0;
   logic                  s_ready;
   logic [32*ROWS-1:0]    frame_data;
   logic [NUM_FRAMES-1:0] frame_strobe;
   logic                  busy, done, error;

   int     checks = 0;
   int     errors = 0;
   frame_t exp_q[$];
   bit     mon_en = 0;
   bit     abort_ok = 0;
   int     strobe_starts = 0;

   config_frame_loader #(
      .ROWS(ROWS), .NUM_FRAMES(NUM_FRAMES), .FRAME_ADDR_W(FRAME_ADDR_W),
      .STROBE_CYCLES(STROBE_CYCLES), .SYNC_WORD(SYNC)
   ) dut (
      .CLK(CLK), .RST(RST), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .frame_data(frame_data), .frame_strobe(frame_strobe),
      .busy(busy), .done(done), .error(error)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hold s_valid until the loader shows s_ready before an edge, bounded so a stuck DUT cannot hang the run.
   task automatic send(input logic [31:0] w, input bit gap);
      bit ok;
      ok = 0;
      if (gap) begin
         s_valid = 1'b0;
         @(posedge CLK); #1;
      end
      s_data  = w;
      s_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CLK);
         if (s_ready) begin
            @(posedge CLK); #1;
            ok = 1;
         end
      end
      s_valid = 1'b0;
      $display("xfer %08h accepted=%0d busy=%0b err=%0b", w, ok, busy, error);
      check("handshake", ok, 1);
   endtask

   function automatic logic [31:0] xor4(input logic [127:0] d);
      return d[31:0] ^ d[63:32] ^ d[95:64] ^ d[127:96];
   endfunction

   task automatic send_frame(input logic [FRAME_ADDR_W-1:0] idx, input logic [127:0] d, input bit gap);
      frame_t f;
      f.idx  = idx;
      f.data = d;
      exp_q.push_back(f);
      send({8'h01, 19'h0, idx}, gap);
      for (int k = 0; k < ROWS; k++) send(d[32*k +: 32], gap);
   endtask

   // Runs after END is accepted: feeds the checksum word when that option is built, then checks the outcome.
   task automatic finish_end(input logic [31:0] csum, input bit ok);
`ifdef CONFIG_FRAME_CHECKSUM_EN
      send(csum, 1'b0);
`else
      if (csum != csum) ok = 1'b0;
`endif
      check("end_done", done, ok);
      check("end_error", error, !ok);
      check("end_busy", busy, 0);
      @(posedge CLK); #1;
      check("done_pulse", done, 0);
   endtask

   task automatic do_end(input logic [31:0] csum, input bit ok);
      send(END_W, 1'b0);
      finish_end(csum, ok);
   endtask

   logic [NUM_FRAMES-1:0] prev_strobe = '0;
   logic [127:0]          held = '0;
   int                    slen = 0;

   always @(negedge CLK) begin
      if (mon_en) begin
         check("onehot0", $onehot0(frame_strobe), 1);
         check("done_and_error", done && error, 0);
         if (frame_strobe != '0) begin
            if (prev_strobe == '0) begin
               frame_t e;
               logic [NUM_FRAMES-1:0] oh;
               strobe_starts++;
               slen = 1;
               held = frame_data;
               check("strobe_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e  = exp_q.pop_front();
                  oh = '0;
                  oh[e.idx] = 1'b1;
                  check("strobe_line", frame_strobe, oh);
                  check("frame_data", frame_data, e.data);
               end
            end else begin
               slen++;
               check("strobe_steady", frame_strobe, prev_strobe);
               check("data_stable", frame_data, held);
            end
         end else if (prev_strobe != '0 && !abort_ok) begin
            check("strobe_len", slen, STROBE_CYCLES);
            check("hold_stable", frame_data, held);
            check("hold_ready", s_ready, 0);
         end
      end
      prev_strobe = frame_strobe;
   end

   localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] D2 = 128'hA5A5A5A5_0F0F0F0F_12345678_CAFEF00D;
   localparam logic [127:0] D3 = 128'h00000001_80000000_FAB0FAB1_DEADBEEF;

   initial begin
      int n;
      int starts;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_strobe", frame_strobe, 0);
      check("rst_data", frame_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_ready", s_ready, 1);
      RST = 1'b0;
      mon_en = 1;

      // Basic frame to index 3.
      send(SYNC, 1'b0);
      check("sync_busy", busy, 1);
      send_frame(5'd3, D1, 1'b0);
      do_end(xor4(D1), 1'b1);

      // Same frame with gaps; END is held valid through STROBE/HOLD.
      send(SYNC, 1'b1);
      send_frame(5'd3, D1, 1'b1);
      s_data  = END_W;
      s_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (s_ready) break;
         n++;
      end
      check("ready_low_cycles", n, STROBE_CYCLES + 1);
      @(posedge CLK); #1;
      s_valid = 1'b0;
      $display("xfer %08h held through strobe", END_W);
      finish_end(xor4(D1), 1'b1);

      // Back-to-back frames at the index boundaries, second frame carries SYNC_WORD as data.
      send(SYNC, 1'b0);
      send_frame(5'd0, D2, 1'b0);
      send_frame(5'd19, D3, 1'b0);
      do_end(xor4(D2) ^ xor4(D3), 1'b1);

      // Out-of-range index.
      starts = strobe_starts;
      send(SYNC, 1'b0);
      send({8'h01, 19'h0, 5'd20}, 1'b0);
      check("idx20_error", error, 1);
      check("idx20_busy", busy, 0);
      repeat (4) @(posedge CLK);
      #1;
      check("idx20_no_strobe", strobe_starts, starts);
      send(SYNC, 1'b0);
      check("sync_clears_error", error, 0);
      do_end(32'h0, 1'b1);

      // Unknown command, then garbage in IDLE.
      send(SYNC, 1'b0);
      send(32'h7F00_0000, 1'b0);
      check("badcmd_error", error, 1);
      send(32'hDEAD_BEEF, 1'b0);
      send(32'hDEAD_BEEF, 1'b0);
      check("garbage_busy", busy, 0);
      check("garbage_error", error, 1);

      // Reset during the first strobe cycle.
      send(SYNC, 1'b0);
      send_frame(5'd7, D2, 1'b0);
      abort_ok = 1;
      RST = 1'b1;
      @(posedge CLK); #1;
      check("abort_strobe", frame_strobe, 0);
      check("abort_data", frame_data, 0);
      check("abort_busy", busy, 0);
      starts = strobe_starts;
      RST = 1'b0;
      repeat (2) @(posedge CLK);
      abort_ok = 0;
      repeat (8) @(posedge CLK);
      #1;
      check("abort_no_strobe", strobe_starts, starts);

`ifdef CONFIG_FRAME_CHECKSUM_EN
      // Wrong checksum after END.
      send(SYNC, 1'b0);
      send_frame(5'd3, D1, 1'b0);
      do_end(32'h0, 1'b0);
`endif

      repeat (3) @(posedge CLK);
      #1;
      check("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
